// File: rtl/flit_sink.sv
`default_nettype none
// ============================================================================
// Module   : flit_sink
// Purpose  : Ejection-side flit consumer for one router's local output port.
//            Reassembles flits per VC into packets, returns one credit per
//            accepted flit after a programmable delay, and queues a
//            completion record per packet in a first-word-fall-through FIFO.
// Options  : SINK_LATENCY_EN - when defined, records carry the packet latency
//            (tail cycle - head cycle) and a max_lat output tracks the
//            largest latency seen. When undefined, the latency field is 0.
// Revision : 1.0 - initial release
// ============================================================================
module flit_sink #(
  parameter int unsigned NUM_VC       = 4,
  parameter int unsigned VC_BITS      = 2,
  parameter int unsigned DST_BITS     = 14,
  parameter int unsigned MY_ID        = 0,
  parameter int unsigned MAX_CR_DELAY = 15,
  parameter int unsigned REC_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3+VC_BITS+DST_BITS-1:0] flit_in,
  input  logic [3:0]                  cfg_credit_delay,
  output logic [VC_BITS:0]            cr_out,
  output logic                        rec_valid,
  output logic [VC_BITS+24-1:0]       rec_data,
  input  logic                        rec_pop,
  output logic [15:0]                 pkt_count,
  output logic                        err_seq,
  output logic                        err_dst,
  output logic                        err_ovf
`ifdef SINK_LATENCY_EN
  ,
  output logic [15:0]                 max_lat
`endif
);

  // --------------------------------------------------------------------------
  // Local constants
  // --------------------------------------------------------------------------
  localparam int unsigned REC_BITS = VC_BITS + 24;
  localparam int unsigned PTR_BITS = (REC_DEPTH > 1) ? $clog2(REC_DEPTH) : 1;
  localparam int unsigned CNT_BITS = PTR_BITS + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
    return (p == PTR_BITS'(REC_DEPTH - 1)) ? '0 : p + PTR_BITS'(1);
  endfunction

  // --------------------------------------------------------------------------
  // Staging word decode
  // --------------------------------------------------------------------------
  logic                f_full;
  logic                f_head;
  logic                f_tail;
  logic [VC_BITS-1:0]  f_vc;
  logic [DST_BITS-1:0] f_dst;

  assign f_full = flit_in[0];
  assign f_head = flit_in[1];
  assign f_tail = flit_in[2];
  assign f_vc   = flit_in[3 +: VC_BITS];
  assign f_dst  = flit_in[3+VC_BITS +: DST_BITS];

  // --------------------------------------------------------------------------
  // Free-running cycle counter (only needed to timestamp packets)
  // --------------------------------------------------------------------------
`ifdef SINK_LATENCY_EN
  logic [15:0] cyc_q;
  logic [15:0] cyc_d;

  assign cyc_d = cyc_q + 16'd1;

  // Timestamp base: wraps freely every 2^16 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end
`endif

  // --------------------------------------------------------------------------
  // Per-VC reassembly FSM
  // --------------------------------------------------------------------------
  logic [0:0] state_q [NUM_VC];
  logic [0:0] state_d [NUM_VC];
  logic [7:0] cnt_q   [NUM_VC];
  logic [7:0] cnt_d   [NUM_VC];
`ifdef SINK_LATENCY_EN
  logic [15:0] t0_q   [NUM_VC];
  logic [15:0] t0_d   [NUM_VC];
`endif

  logic        comp_valid;
  logic [7:0]  comp_nf;
  logic [15:0] comp_lat;
  logic        seq_hit;

  // State register: per-VC state, flit count and head timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        state_q[v] <= ST_IDLE;
        cnt_q[v]   <= '0;
`ifdef SINK_LATENCY_EN
        t0_q[v]    <= '0;
`endif
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        state_q[v] <= state_d[v];
        cnt_q[v]   <= cnt_d[v];
`ifdef SINK_LATENCY_EN
        t0_q[v]    <= t0_d[v];
`endif
      end
    end
  end

  // Next state: only the VC named by the incoming flit can change.
  // A head always (re)starts a packet, even on a BUSY VC, so the partial
  // packet is simply overwritten.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      state_d[v] = state_q[v];
      cnt_d[v]   = cnt_q[v];
`ifdef SINK_LATENCY_EN
      t0_d[v]    = t0_q[v];
`endif
    end
    if (f_full) begin
      if (f_head) begin
        if (f_tail) begin
          state_d[f_vc] = ST_IDLE;
        end else begin
          state_d[f_vc] = ST_BUSY;
          cnt_d[f_vc]   = 8'd1;
`ifdef SINK_LATENCY_EN
          t0_d[f_vc]    = cyc_q;
`endif
        end
      end else if (state_q[f_vc] == ST_BUSY) begin
        if (f_tail) state_d[f_vc] = ST_IDLE;
        else        cnt_d[f_vc]   = sat_inc(cnt_q[f_vc]);
      end
    end
  end

  // Outputs of the FSM: completion strobe, record fields and sequence error.
  always_comb begin
    comp_valid = 1'b0;
    comp_nf    = '0;
    comp_lat   = '0;
    seq_hit    = 1'b0;
    if (f_full) begin
      if (f_head) begin
        seq_hit = (state_q[f_vc] == ST_BUSY);
        if (f_tail) begin
          comp_valid = 1'b1;
          comp_nf    = 8'd1;
        end
      end else if (state_q[f_vc] == ST_BUSY) begin
        if (f_tail) begin
          comp_valid = 1'b1;
          comp_nf    = sat_inc(cnt_q[f_vc]);
`ifdef SINK_LATENCY_EN
          comp_lat   = cyc_q - t0_q[f_vc];
`endif
        end
      end else begin
        // body or tail with no packet open on this VC
        seq_hit = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Completion record FIFO (first-word-fall-through, registered head)
  // --------------------------------------------------------------------------
  logic [REC_BITS-1:0] mem_q [REC_DEPTH];
  logic [REC_BITS-1:0] mem_d [REC_DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                rec_valid_q, rec_valid_d;
  logic [REC_BITS-1:0] rec_data_q, rec_data_d;

  logic                fifo_full;
  logic                do_pop;
  logic                do_push;
  logic                drop;
  logic [REC_BITS-1:0] comp_rec;

  assign fifo_full = (count_q == CNT_BITS'(REC_DEPTH));
  assign do_pop    = rec_pop && rec_valid_q;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push   = comp_valid && (!fifo_full || do_pop);
  assign drop      = comp_valid && fifo_full && !do_pop;
  assign comp_rec  = {f_vc, comp_nf, comp_lat};

  // FIFO next state; the head register is loaded from the post-update
  // storage so a push into an empty FIFO is visible right after the edge.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = comp_rec;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
    rec_valid_d = (count_d != '0);
    rec_data_d  = rec_valid_d ? mem_d[rd_ptr_d] : '0;
  end

  // FIFO storage, pointers and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REC_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rec_valid_q <= 1'b0;
      rec_data_q  <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rec_valid_q <= rec_valid_d;
      rec_data_q  <= rec_data_d;
    end
  end

  assign rec_valid = rec_valid_q;
  assign rec_data  = rec_data_q;

  // --------------------------------------------------------------------------
  // Packet counter and sticky error flags
  // --------------------------------------------------------------------------
  logic [15:0] pkt_count_q, pkt_count_d;
  logic        err_seq_q, err_seq_d;
  logic        err_dst_q, err_dst_d;
  logic        err_ovf_q, err_ovf_d;
`ifdef SINK_LATENCY_EN
  logic [15:0] max_lat_q, max_lat_d;
`endif

  // Status next state; dropped records still count as completed packets.
  always_comb begin
    pkt_count_d = comp_valid ? pkt_count_q + 16'd1 : pkt_count_q;
    err_seq_d   = err_seq_q | seq_hit;
    err_dst_d   = err_dst_q | (f_full && (f_dst != DST_BITS'(MY_ID)));
    err_ovf_d   = err_ovf_q | drop;
`ifdef SINK_LATENCY_EN
    max_lat_d   = (comp_valid && (comp_lat > max_lat_q)) ? comp_lat : max_lat_q;
`endif
  end

  // Status registers; the error flags only clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_q <= '0;
      err_seq_q   <= 1'b0;
      err_dst_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
`ifdef SINK_LATENCY_EN
      max_lat_q   <= '0;
`endif
    end else begin
      pkt_count_q <= pkt_count_d;
      err_seq_q   <= err_seq_d;
      err_dst_q   <= err_dst_d;
      err_ovf_q   <= err_ovf_d;
`ifdef SINK_LATENCY_EN
      max_lat_q   <= max_lat_d;
`endif
    end
  end

  assign pkt_count = pkt_count_q;
  assign err_seq   = err_seq_q;
  assign err_dst   = err_dst_q;
  assign err_ovf   = err_ovf_q;
`ifdef SINK_LATENCY_EN
  assign max_lat   = max_lat_q;
`endif

  // --------------------------------------------------------------------------
  // Credit return delay line
  // --------------------------------------------------------------------------
  // Entry i holds a flit accepted i+1 edges ago; the registered output adds
  // one more edge, so tapping entry D-1 yields a credit D edges after accept.
  logic [VC_BITS:0] line_q [MAX_CR_DELAY];
  logic [VC_BITS:0] line_d [MAX_CR_DELAY];
  logic [VC_BITS:0] cr_q, cr_d;
  int               tap_idx;

  // Shift the valid/vc line and select the tap for the configured delay.
  always_comb begin
    line_d[0] = f_full ? {f_vc, 1'b1} : '0;
    for (int i = 1; i < MAX_CR_DELAY; i++) line_d[i] = line_q[i-1];
    tap_idx = (cfg_credit_delay == 4'd0) ? 0 : int'(cfg_credit_delay) - 1;
    if (tap_idx > int'(MAX_CR_DELAY) - 1) tap_idx = int'(MAX_CR_DELAY) - 1;
    cr_d = '0;
    for (int i = 0; i < MAX_CR_DELAY; i++) begin
      if (tap_idx == i) cr_d = line_q[i];
    end
  end

  // Delay line and credit output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_CR_DELAY; i++) line_q[i] <= '0;
      cr_q <= '0;
    end else begin
      line_q <= line_d;
      cr_q   <= cr_d;
    end
  end

  assign cr_out = cr_q;

endmodule
`default_nettype wire

// File: doc/flit_sink.md
Name: flit_sink

Overview:
Ejection-side consumer attached to a router's local output staging port (port 0). It accepts ejected flits and reassembles them per VC into packets. It returns one credit per accepted flit after a programmable credit delay, and queues one completion record per packet for the top-level bench to drain. One instance sits downstream of each router, mirroring the per-router traffic source on the injection side.

Parameters:
NUM_VC, 4, number of virtual channels.
VC_BITS, 2, width of the VC field, log2(NUM_VC).
DST_BITS, 14, width of the flit destination field.
MY_ID, 0, router index this sink belongs to, compared against the flit dst.
MAX_CR_DELAY, 15, maximum credit delay in cycles (delay line depth).
REC_DEPTH, 4, completion record FIFO depth, power of 2.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
flit_in  in  3+VC_BITS+DST_BITS  staging word: [0] full, [1] head, [2] tail, [3+:VC_BITS] vc, [3+VC_BITS+:DST_BITS] dst.
cfg_credit_delay  in  4  credit return delay in cycles; 0 treated as 1.
cr_out  out  1+VC_BITS  credit word: [0] valid, [1+:VC_BITS] vc.
rec_valid  out  1  completion FIFO non-empty.
rec_data  out  VC_BITS+24  {vc, num_flit[7:0], latency[15:0]} at FIFO head.
rec_pop  in  1  dequeue strobe, ignored when empty.
pkt_count  out  16  total completed packets, wraps at 2^16.
err_seq  out  1  sticky: protocol sequence violation.
err_dst  out  1  sticky: flit dst != MY_ID.
err_ovf  out  1  sticky: record dropped because FIFO full.

Behaviour:
- Reset (rst_n=0, async): all outputs 0, all VCs IDLE, FIFO empty, delay line cleared, free-running cycle counter = 0.
- cyc: 16-bit free-running counter, increments every cycle, wraps.
- A flit is accepted when flit_in[0]=1. A flit with flit_in[0]=0 is ignored entirely.
- Per-VC FSM, states IDLE and BUSY; per-VC registers cnt[7:0] and t0[15:0].
  - IDLE + head, no tail: go to BUSY, cnt=1, t0=cyc.
  - IDLE + head + tail: single-flit packet, complete with num_flit=1, latency=0, stay IDLE.
  - BUSY + body (no head, no tail): cnt=cnt+1, saturating at 255.
  - BUSY + tail: complete with num_flit=cnt+1 (saturating), latency=cyc-t0 (mod 2^16), go to IDLE.
  - IDLE + body or tail: set err_seq, no record, stay IDLE; a credit is still returned.
  - BUSY + head: set err_seq, discard the partial packet, restart as if IDLE + head.
- dst check: every accepted flit with dst != MY_ID sets err_dst. The flit is still processed normally.
- Completion:
  - Completion pushes {vc, num_flit, latency} into the FIFO and increments pkt_count in the same cycle.
  - FIFO full and no simultaneous pop: record dropped, err_ovf set, pkt_count still increments.
  - Simultaneous push and pop on a full FIFO: both succeed.
- FIFO is first-word-fall-through:
  - rec_valid and rec_data are registered and reflect the head entry.
  - rec_pop with rec_valid=1 advances the head on the next edge.
  - rec_pop while empty has no effect.
- Credit return:
  - Each accepted flit enters a MAX_CR_DELAY-deep valid/vc shift line.
  - cr_out is the tap at D = max(cfg_credit_delay,1), so a flit accepted at edge N produces cr_out valid after edge N+D.
  - Exactly one credit per accepted flit, including error flits.
  - cfg_credit_delay must stay static while credits are in flight; changing it then may lose or duplicate credits.
- Sticky errors clear only on reset.
- Latency: one flit at most per cycle (single ejection port). No backpressure toward the router; the sink always accepts.

Optional Feature:
SINK_LATENCY_EN:
- Defined: latency field computed as above, plus an extra output max_lat[15:0] (reset 0) holding the maximum latency of all completed packets, including dropped records.
- Undefined: latency field of rec_data is constant 0, t0 registers and the max_lat port are absent, and all other behaviour is identical.

Test Plan:
- Reset mid-packet: head on vc1, then assert rst_n=0 -> all outputs 0 immediately. After release, a tail on vc1 sets err_seq=1 and pkt_count stays 0.
- 3-flit packet, cfg_credit_delay=2:
  - Stimulus: head at cycle 10, body at cycle 11, tail at cycle 12, all on vc2, dst=MY_ID.
  - Record {vc=2, num_flit=3, latency=2}; pkt_count=1.
  - cr_out valid with vc=2 on 3 consecutive cycles, starting 2 cycles after the head.
- Interleaved VCs: alternate flits of a 2-flit vc0 packet and a 4-flit vc3 packet -> records in completion order {0,2,..} then {3,4,..}; err_seq=0.
- Overflow, REC_DEPTH=4: 5 single-flit packets, no pops -> 4 records held, err_ovf=1, pkt_count=5. Then 4 pops -> rec_valid=0.
- Error flits:
  - Head with dst=MY_ID+1 -> err_dst=1 and the packet still completes.
  - Head on a BUSY VC -> err_seq=1 and the new packet's num_flit counts from the restarting head.
- cfg_credit_delay=0 and =15: single flit -> credit after 1 and after 15 cycles respectively; never duplicated.
